// File: rtl/generic_bus_manager.sv
// GenericBus initiator: turns a valid/ready command stream into single or INCR/WRAP burst transfers.
// Optional busy watchdog enabled by defining GENERIC_BUS_MANAGER_TIMEOUT_EN.
module generic_bus_manager #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int LenWidth      = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [AddrWidth-1:0]   cmd_addr,
    input  logic [LenWidth-1:0]    cmd_len,
    input  logic                   cmd_wrap,
    input  logic [2:0]             cmd_prot,
    input  logic                   cmd_nonsec,
    input  logic                   wd_valid,
    output logic                   wd_ready,
    input  logic [DataWidth-1:0]   wd_data,
    input  logic [DataWidth/8-1:0] wd_strb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DataWidth-1:0]   rsp_rdata,
    output logic                   rsp_error,
    output logic                   rsp_last,
    output logic [AddrWidth-1:0]   bus_addr,
    output logic [DataWidth-1:0]   bus_wData,
    output logic [DataWidth/8-1:0] bus_wStrb,
    output logic                   bus_wEn,
    output logic                   bus_rEn,
    output logic                   bus_isBurst,
    output logic                   bus_burstType,
    output logic [LenWidth-1:0]    bus_burstLen,
    output logic                   bus_nonSec,
    output logic [2:0]             bus_prot,
    input  logic [DataWidth-1:0]   bus_rData,
    input  logic                   bus_error,
    input  logic                   bus_busy
);

    localparam int Bpb      = DataWidth / 8;
    localparam int BpbShift = $clog2(Bpb);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RRESP,
        ST_WRITE,
        ST_WRESP
    } state_t;

    state_t state_reg, state_next;

    logic [AddrWidth-1:0] addr_reg;
    logic [LenWidth-1:0]  cnt_reg;
    logic [LenWidth-1:0]  len_reg;
    logic                 wrap_reg;
    logic                 isburst_reg;
    logic [2:0]           prot_reg;
    logic                 nonsec_reg;
    logic [DataWidth-1:0] rdata_reg;
    logic                 rerr_reg;
    logic                 rlast_reg;
    logic                 werr_reg;

    logic                 rd_active;
    logic                 wr_active;
    logic                 bus_en;
    logic                 timeout_hit;
    logic                 beat_done;
    logic                 beat_err;
    logic                 cnt_zero;
    logic [AddrWidth-1:0] addr_incr;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] addr_step;
    logic [DataWidth-1:0] wdata_gated;
    logic [Bpb-1:0]       wstrb_gated;

    assign rd_active = (state_reg == ST_READ);
    assign wr_active = (state_reg == ST_WRITE) & wd_valid;
    assign bus_en    = rd_active | wr_active;
    assign cnt_zero  = (cnt_reg == '0);

    // A timed-out beat completes like a normal one but always carries an error.
    assign beat_done = bus_en & (~bus_busy | timeout_hit);
    assign beat_err  = timeout_hit | (~bus_busy & bus_error);

    // WRAP keeps the upper address bits and wraps the low bits inside a span of (len+1) beats.
    assign addr_incr = addr_reg + AddrWidth'(Bpb);
    assign wrap_mask = ((AddrWidth'(len_reg) + AddrWidth'(1)) << BpbShift) - AddrWidth'(1);
    assign addr_step = wrap_reg ? ((addr_reg & ~wrap_mask) | (addr_incr & wrap_mask)) : addr_incr;

`ifdef GENERIC_BUS_MANAGER_TIMEOUT_EN
    localparam int ToWidth = $clog2(TimeoutCycles + 1);

    logic [ToWidth-1:0] to_cnt_reg, to_cnt_next;

    assign timeout_hit = bus_en & bus_busy & (to_cnt_reg == ToWidth'(TimeoutCycles - 1));

    always_comb begin
        to_cnt_next = to_cnt_reg;
        if (!bus_en || beat_done) begin
            to_cnt_next = '0;
        end else if (bus_busy) begin
            to_cnt_next = to_cnt_reg + ToWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_next;
        end
    end
`else
    // Stalls are unbounded; the limit parameter only matters when the watchdog is built in.
    assign timeout_hit = (TimeoutCycles < 0);
`endif

    // Write lanes pass through only while a write beat is actually being driven.
    for (genvar gi = 0; gi < Bpb; gi++) begin : g_lane
        assign wdata_gated[gi*8 +: 8] = wr_active ? wd_data[gi*8 +: 8] : 8'h00;
        assign wstrb_gated[gi]        = wr_active & wd_strb[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (beat_done) begin
                    state_next = ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (rsp_ready) begin
                    state_next = rlast_reg ? ST_IDLE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (beat_done && (cnt_zero || beat_err)) begin
                    state_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg    <= '0;
            cnt_reg     <= '0;
            len_reg     <= '0;
            wrap_reg    <= 1'b0;
            isburst_reg <= 1'b0;
            prot_reg    <= 3'b000;
            nonsec_reg  <= 1'b0;
            rdata_reg   <= '0;
            rerr_reg    <= 1'b0;
            rlast_reg   <= 1'b0;
            werr_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_reg    <= cmd_addr;
                        cnt_reg     <= cmd_len;
                        len_reg     <= cmd_len;
                        wrap_reg    <= cmd_wrap;
                        isburst_reg <= (cmd_len != '0);
                        prot_reg    <= cmd_prot;
                        nonsec_reg  <= cmd_nonsec;
                        werr_reg    <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (beat_done) begin
                        rdata_reg <= bus_rData;
                        rerr_reg  <= beat_err;
                        rlast_reg <= cnt_zero | beat_err;
                    end
                end
                ST_RRESP: begin
                    if (rsp_ready && !rlast_reg) begin
                        addr_reg <= addr_step;
                        cnt_reg  <= cnt_reg - LenWidth'(1);
                    end
                end
                ST_WRITE: begin
                    if (beat_done) begin
                        werr_reg <= werr_reg | beat_err;
                        if (!cnt_zero) begin
                            addr_reg <= addr_step;
                            cnt_reg  <= cnt_reg - LenWidth'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        cmd_ready     = 1'b0;
        wd_ready      = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_error     = 1'b0;
        rsp_last      = 1'b0;
        bus_addr      = '0;
        bus_wData     = wdata_gated;
        bus_wStrb     = wstrb_gated;
        bus_wEn       = wr_active;
        bus_rEn       = rd_active;
        bus_isBurst   = 1'b0;
        bus_burstType = 1'b0;
        bus_burstLen  = '0;
        bus_nonSec    = 1'b0;
        bus_prot      = 3'b000;
        if (state_reg != ST_IDLE) begin
            bus_isBurst   = isburst_reg;
            bus_burstType = wrap_reg;
            bus_burstLen  = len_reg;
            bus_nonSec    = nonsec_reg;
            bus_prot      = prot_reg;
        end
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_READ: begin
                bus_addr = addr_reg;
            end
            ST_RRESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_reg;
                rsp_error = rerr_reg;
                rsp_last  = rlast_reg;
            end
            ST_WRITE: begin
                bus_addr = addr_reg;
                wd_ready = wr_active & (~bus_busy | timeout_hit);
            end
            ST_WRESP: begin
                rsp_valid = 1'b1;
                rsp_error = werr_reg;
                rsp_last  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_generic_bus_manager.sv
// Directed bench for generic_bus_manager: single read, INCR write, WRAP read, errors, backpressure, reset, watchdog.
module tb_generic_bus_manager;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        cmd_wrap;
    logic [2:0]  cmd_prot;
    logic        cmd_nonsec;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_last;
    logic [31:0] bus_addr;
    logic [31:0] bus_wData;
    logic [3:0]  bus_wStrb;
    logic        bus_wEn;
    logic        bus_rEn;
    logic        bus_isBurst;
    logic        bus_burstType;
    logic [3:0]  bus_burstLen;
    logic        bus_nonSec;
    logic [2:0]  bus_prot;
    logic [31:0] bus_rData;
    logic        bus_error;
    logic        bus_busy;

    int total = 0;
    int bad   = 0;

    generic_bus_manager #(
        .AddrWidth(32), .DataWidth(32), .LenWidth(4), .TimeoutCycles(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wrap(cmd_wrap),
        .cmd_prot(cmd_prot), .cmd_nonsec(cmd_nonsec),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_last(rsp_last),
        .bus_addr(bus_addr), .bus_wData(bus_wData), .bus_wStrb(bus_wStrb),
        .bus_wEn(bus_wEn), .bus_rEn(bus_rEn), .bus_isBurst(bus_isBurst),
        .bus_burstType(bus_burstType), .bus_burstLen(bus_burstLen),
        .bus_nonSec(bus_nonSec), .bus_prot(bus_prot),
        .bus_rData(bus_rData), .bus_error(bus_error), .bus_busy(bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [3:0] l, input logic w);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_wrap  = w;
        cmd_valid = 1'b1;
        #2;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        $display("cmd accepted: write=%0d addr=%h len=%0d wrap=%0d", wr, a, l, w);
    endtask

    logic [31:0] wrap_exp [4];
    int          n;
    logic        seen;

    initial begin
        wrap_exp[0] = 32'h38; wrap_exp[1] = 32'h3C; wrap_exp[2] = 32'h30; wrap_exp[3] = 32'h34;
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_wrap = 0;
        cmd_prot = 0; cmd_nonsec = 0; wd_valid = 0; wd_data = 0; wd_strb = 0;
        rsp_ready = 0; bus_rData = 0; bus_error = 0; bus_busy = 0;
        tick(); tick();
        reset = 1'b0;
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rEn", bus_rEn, 0);
        chk("rst_wEn", bus_wEn, 0);
        chk("rst_addr", bus_addr, 0);
        $display("reset state checked");

        // single read
        tick();
        send_cmd(1'b0, 32'h100, 4'd0, 1'b0);
        bus_rData = 32'hDEADBEEF;
        #2;
        chk("rd1_rEn", bus_rEn, 1);
        chk("rd1_addr", bus_addr, 32'h100);
        chk("rd1_isBurst", bus_isBurst, 0);
        chk("rd1_rsp_early", rsp_valid, 0);
        tick();
        rsp_ready = 1'b1;
        #2;
        chk("rd1_rsp_valid", rsp_valid, 1);
        chk("rd1_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd1_err", rsp_error, 0);
        chk("rd1_last", rsp_last, 1);
        chk("rd1_rEn_off", bus_rEn, 0);
        $display("single read rsp data=%h err=%0d last=%0d", rsp_rdata, rsp_error, rsp_last);
        tick();
        #2;
        chk("rd1_idle", cmd_ready, 1);
        chk("rd1_rsp_gone", rsp_valid, 0);

        // INCR write burst with a 2-cycle busy stall and a wd_valid gap
        cmd_prot = 3'b101; cmd_nonsec = 1'b1;
        send_cmd(1'b1, 32'h200, 4'd3, 1'b0);
        cmd_prot = 3'b000; cmd_nonsec = 1'b0;
        wd_valid = 1'b1; wd_data = 32'hA0A00000; wd_strb = 4'hF;
        #2;
        chk("wr_b0_wEn", bus_wEn, 1);
        chk("wr_b0_addr", bus_addr, 32'h200);
        chk("wr_b0_ready", wd_ready, 1);
        chk("wr_b0_wData", bus_wData, 32'hA0A00000);
        chk("wr_isBurst", bus_isBurst, 1);
        chk("wr_burstLen", bus_burstLen, 3);
        chk("wr_burstType", bus_burstType, 0);
        chk("wr_prot", bus_prot, 3'b101);
        chk("wr_nonSec", bus_nonSec, 1);
        tick();
        wd_data = 32'hA0A00001; bus_busy = 1'b1;
        #2;
        chk("wr_b1_busy1_addr", bus_addr, 32'h204);
        chk("wr_b1_busy1_ready", wd_ready, 0);
        chk("wr_b1_busy1_wEn", bus_wEn, 1);
        tick();
        #2;
        chk("wr_b1_busy2_addr", bus_addr, 32'h204);
        chk("wr_b1_busy2_ready", wd_ready, 0);
        tick();
        bus_busy = 1'b0; wd_strb = 4'b0101;
        #2;
        chk("wr_b1_ready", wd_ready, 1);
        chk("wr_b1_addr", bus_addr, 32'h204);
        chk("wr_b1_strb", bus_wStrb, 4'b0101);
        tick();
        wd_valid = 1'b0; wd_strb = 4'hF;
        #2;
        chk("wr_gap_wEn", bus_wEn, 0);
        chk("wr_gap_ready", wd_ready, 0);
        chk("wr_gap_addr", bus_addr, 32'h208);
        tick();
        wd_valid = 1'b1; wd_data = 32'hA0A00002;
        #2;
        chk("wr_b2_ready", wd_ready, 1);
        chk("wr_b2_addr", bus_addr, 32'h208);
        tick();
        wd_data = 32'hA0A00003;
        #2;
        chk("wr_b3_ready", wd_ready, 1);
        chk("wr_b3_addr", bus_addr, 32'h20C);
        tick();
        wd_valid = 1'b0;
        #2;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_last", rsp_last, 1);
        chk("wr_rsp_err", rsp_error, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_wEn", bus_wEn, 0);
        $display("incr write rsp err=%0d last=%0d", rsp_error, rsp_last);
        tick();
        #2;
        chk("wr_idle", cmd_ready, 1);
        chk("wr_idle_isBurst", bus_isBurst, 0);

        // WRAP read burst
        send_cmd(1'b0, 32'h38, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus_rData = 32'hA0 + 32'(i);
            #2;
            chk("wrap_rEn", bus_rEn, 1);
            chk("wrap_addr", bus_addr, wrap_exp[i]);
            chk("wrap_type", bus_burstType, 1);
            tick();
            #2;
            chk("wrap_rsp_valid", rsp_valid, 1);
            chk("wrap_rdata", rsp_rdata, 32'hA0 + 32'(i));
            chk("wrap_last", rsp_last, (i == 3) ? 1 : 0);
            $display("wrap beat %0d addr=%h rdata=%h last=%0d", i, wrap_exp[i], rsp_rdata, rsp_last);
            tick();
        end
        #2;
        chk("wrap_idle", cmd_ready, 1);

        // read error on the second beat
        send_cmd(1'b0, 32'h400, 4'd3, 1'b0);
        bus_rData = 32'h1;
        #2;
        chk("rerr_b0_addr", bus_addr, 32'h400);
        tick();
        #2;
        chk("rerr_b0_last", rsp_last, 0);
        chk("rerr_b0_err", rsp_error, 0);
        tick();
        bus_rData = 32'h2; bus_error = 1'b1;
        #2;
        chk("rerr_b1_addr", bus_addr, 32'h404);
        tick();
        bus_error = 1'b0;
        #2;
        chk("rerr_rsp_valid", rsp_valid, 1);
        chk("rerr_rsp_err", rsp_error, 1);
        chk("rerr_rsp_last", rsp_last, 1);
        $display("read error rsp err=%0d last=%0d", rsp_error, rsp_last);
        tick();
        #2;
        chk("rerr_idle", cmd_ready, 1);
        chk("rerr_no_rEn", bus_rEn, 0);
        tick();
        #2;
        chk("rerr_no_rEn2", bus_rEn, 0);

        // write error on the first beat ends the command early
        send_cmd(1'b1, 32'h600, 4'd1, 1'b0);
        wd_valid = 1'b1; wd_data = 32'h55; bus_error = 1'b1;
        #2;
        chk("werr_ready", wd_ready, 1);
        tick();
        wd_valid = 1'b0; bus_error = 1'b0;
        #2;
        chk("werr_rsp_valid", rsp_valid, 1);
        chk("werr_rsp_err", rsp_error, 1);
        chk("werr_rsp_last", rsp_last, 1);
        $display("write error rsp err=%0d", rsp_error);
        tick();
        #2;
        chk("werr_idle", cmd_ready, 1);

        // response backpressure, then reset mid-burst
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h500, 4'd3, 1'b0);
        bus_rData = 32'h11111111;
        tick();
        bus_rData = 32'h0BAD0BAD;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'h11111111);
            chk("bp_rEn", bus_rEn, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        #2;
        chk("bp_b1_rEn", bus_rEn, 1);
        chk("bp_b1_addr", bus_addr, 32'h504);
        reset = 1'b1;
        tick();
        #2;
        chk("rst_mid_rEn", bus_rEn, 0);
        chk("rst_mid_wEn", bus_wEn, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_addr", bus_addr, 0);
        $display("mid-burst reset: cmd_ready=%0d rEn=%0d", cmd_ready, bus_rEn);
        reset = 1'b0;
        tick();

        // busy held high
        send_cmd(1'b0, 32'h700, 4'd0, 1'b0);
        bus_busy = 1'b1;
`ifdef GENERIC_BUS_MANAGER_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        #2;
        chk("to_cycles", n, 8);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_error, 1);
        chk("to_rsp_last", rsp_last, 1);
        $display("timeout response after %0d cycles err=%0d", n, rsp_error);
        bus_busy = 1'b0;
        tick();
        #2;
        chk("to_idle", cmd_ready, 1);
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        #2;
        chk("stall_no_rsp", seen, 0);
        chk("stall_rEn", bus_rEn, 1);
        chk("stall_addr", bus_addr, 32'h700);
        $display("unbounded stall: no response in 100 cycles");
        bus_busy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("stall_reset_idle", cmd_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/generic_bus_manager.md
Name: generic_bus_manager

Overview:
- Initiator end of the GenericBus protocol. Converts a valid/ready command stream into GenericBus read/write transfers, including multi-beat INCR and WRAP bursts.
- Honours subordinate `busy` stalls and returns read data and error status on a valid/ready response stream.
- Sits between a CPU/DMA-style requester and address-decoding subordinates on the bus.

Parameters:
- AddrWidth, 32, width of `cmd_addr` and `bus_addr`.
- DataWidth, 32, data width; a power of two and at least 8. Bytes per beat: BPB = DataWidth/8.
- LenWidth, 4, width of `cmd_len` and `bus_burstLen`. Beats per command = `cmd_len` + 1.
- TimeoutCycles, 256, busy-watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with `cmd_valid`
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AddrWidth  start byte address, BPB-aligned
- cmd_len  in  LenWidth  beats minus 1
- cmd_wrap  in  1  0 = INCR, 1 = WRAP
- cmd_prot  in  3  copied to `bus_prot`
- cmd_nonsec  in  1  copied to `bus_nonSec`
- wd_valid  in  1  write-data beat offered
- wd_ready  out  1  write beat consumed
- wd_data  in  DataWidth  write data
- wd_strb  in  BPB  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DataWidth  read data; 0 for writes
- rsp_error  out  1  transfer error
- rsp_last  out  1  final response of the command
- bus_addr  out  AddrWidth  GenericBus `addr`
- bus_wData  out  DataWidth  GenericBus `wData`
- bus_wStrb  out  BPB  GenericBus `wStrb`
- bus_wEn  out  1  GenericBus `wEn`
- bus_rEn  out  1  GenericBus `rEn`
- bus_isBurst  out  1  high when `cmd_len` != 0
- bus_burstType  out  1  0 = INCR, 1 = WRAP
- bus_burstLen  out  LenWidth  registered `cmd_len`
- bus_nonSec  out  1  GenericBus `nonSec`
- bus_prot  out  3  GenericBus `prot`
- bus_rData  in  DataWidth  GenericBus `rData`
- bus_error  in  1  GenericBus `error`
- bus_busy  in  1  GenericBus `busy`

Behaviour:
- Reset:
  - State → IDLE.
  - All outputs 0, except `cmd_ready` = 1.
  - Takes effect the cycle after `reset` is sampled high, including mid-burst. No response is emitted for an aborted command.
- Beat completion: a beat completes in a cycle where (`bus_rEn` | `bus_wEn`) = 1 and `bus_busy` = 0. `bus_rData` and `bus_error` are sampled in that cycle.
- FSM states:
  - IDLE:
    - `cmd_ready` = 1.
    - On `cmd_valid`: register command, beat counter = `cmd_len`, go to READ or WRITE.
  - READ:
    - `bus_rEn` = 1 and `bus_addr` = current address.
    - On completion: capture `rsp_rdata`/`rsp_error`; `rsp_last` = (counter == 0) | error; go to RRESP.
  - RRESP:
    - `rsp_valid` = 1 and `bus_rEn` = 0.
    - On `rsp_ready`: if `rsp_last` go to IDLE; else advance address, decrement counter, go to READ.
  - WRITE:
    - `bus_wEn` = `wd_valid`; `bus_wData`/`bus_wStrb` come from `wd_*` combinationally.
    - `wd_ready` = `wd_valid` & ~`bus_busy`.
    - On completion: OR `bus_error` into the sticky error flag and advance the beat.
    - After the last beat, or on error, go to WRESP.
  - WRESP:
    - `rsp_valid` = 1, `rsp_last` = 1, `rsp_error` = sticky flag, `rsp_rdata` = 0.
    - On `rsp_ready`, go to IDLE.
- Latency: command accepted at cycle N → `bus_rEn` at N+1. With `busy` = 0, `rsp_valid` at N+2. Read throughput is at most 1 beat per 2 cycles.
- Address update is computed at AddrWidth with modulo wrap at 2^AddrWidth:
  - INCR: addr + BPB.
  - WRAP: span = (`cmd_len`+1)*BPB, with `cmd_len`+1 a power of two. addr = (addr & ~(span-1)) | ((addr + BPB) & (span-1)).
- `bus_burstType`, `bus_burstLen`, `bus_isBurst`, `bus_prot` and `bus_nonSec` hold the registered command values while not IDLE, and are 0 in IDLE.
- Error:
  - A beat with `bus_error` = 1 terminates the command; remaining beats are not issued.
  - For reads, that response carries `rsp_error` = 1 and `rsp_last` = 1.
  - Unused write-data beats stay on the wd stream; the requester must discard them.
- `wd_valid` low in WRITE: enables are 0 and no beat advances.
- `bus_busy` held high: enables stay asserted and address is stable, indefinitely unless the optional feature is enabled.

Optional Feature:
- Macro: GENERIC_BUS_MANAGER_TIMEOUT_EN.
- Defined:
  - A counter increments in each cycle with an enable asserted and `bus_busy` = 1, and clears on beat completion.
  - On reaching TimeoutCycles, the beat is treated as complete with error = 1; the error path above applies.
- Undefined: no counter; stalls are unbounded.

Test Plan:
- Single read: `cmd_addr` = 0x100, `cmd_len` = 0, `bus_busy` = 0, `bus_rData` = 0xDEADBEEF → `bus_rEn` one cycle with addr 0x100; response 0xDEADBEEF, error 0, last 1, 2 cycles after accept.
- INCR write burst: addr 0x200, len 3, four wd beats, busy 2 cycles on beat 1 → `bus_addr` 0x200/0x204/0x208/0x20C; `wd_ready` only on completing cycles; one response with error 0.
- WRAP read: addr 0x38, len 3 → beat addresses 0x38, 0x30, 0x34, 0x3C? No: 0x38, 0x3C, 0x30, 0x34. Four responses, last on the 4th.
- Error mid-read: len 3, `bus_error` = 1 on beat 2 → 2 responses, the second with error = 1 and last = 1; no 3rd `rEn`; `cmd_ready` high after.
- Backpressure plus reset: `rsp_ready` = 0 for 5 cycles holds `rsp_valid` with stable data and `bus_rEn` = 0; asserting `reset` mid-burst → next cycle all bus enables 0, `rsp_valid` 0, `cmd_ready` 1.
- Timeout (macro defined, TimeoutCycles = 8): busy held high → error response after 8 stalled cycles. Macro undefined: no response after 100 cycles.
